// File: rtl/v_lane_sequencer.sv
// rtl/v_lane_sequencer.sv - issue sequencer strip-mining an LMUL group over the vector lane groups
module v_lane_sequencer #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    input  logic [1:0] lmul,
    input  logic [1:0] lanes,
    input  logic       hold,
    output logic       busy,
    output logic       issue_valid,
    output logic [1:0] pass_idx,
    output logic [3:0] grp_en,
    output logic [7:0] op_sel,
    output logic [3:0] wr_en,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t     state;
    logic [1:0] lmul_q;
    logic [1:0] lanes_q;
    logic [1:0] pcnt;
    logic [2:0] dcnt;
    logic       iv_q;
    logic [3:0] grp_q;
    logic [7:0] op_q;
    logic [3:0] cm_q;
    logic       done_q;
    logic       err_q;
    logic [3:0] pipe [0:LAT-1];

    // {chunk mask, group mask, op_sel} for pass p; group k is active while p*G+k < N
    function automatic logic [15:0] map_pass(logic [1:0] p, logic [1:0] lm, logic [1:0] ln);
        logic [3:0] g_m;
        logic [3:0] c_m;
        logic [7:0] o;
        int n;
        int g;
        int idx;
        n   = 1 << lm;
        g   = 1 << ln;
        g_m = '0;
        c_m = '0;
        o   = '0;
        for (int k = 0; k < 4; k++) begin
            idx = int'(p) * g + k;
            if (k < g && idx < n) begin
                g_m[k]       = 1'b1;
                c_m[idx[1:0]] = 1'b1;
                o[2*k +: 2]  = idx[1:0];
            end
        end
        return {c_m, g_m, o};
    endfunction

    function automatic logic [1:0] last_pass(logic [1:0] lm, logic [1:0] ln);
        logic [2:0] np;
        np = (lm > ln) ? (3'd1 << (lm - ln)) : 3'd1;
        return 2'(np - 3'd1);
    endfunction

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= S_IDLE;
            lmul_q  <= '0;
            lanes_q <= '0;
            pcnt    <= '0;
            dcnt    <= '0;
            iv_q    <= 1'b0;
            grp_q   <= '0;
            op_q    <= '0;
            cm_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            err_q <= 1'b0;
            if (!hold) begin
                pipe[0] <= iv_q ? cm_q : 4'b0;
                for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (lmul == 2'b11 || lanes == 2'b11) begin
                                err_q <= 1'b1;
                            end else begin
                                lmul_q  <= lmul;
                                lanes_q <= lanes;
                                state   <= S_ISSUE;
                                pcnt    <= '0;
                                iv_q    <= 1'b1;
                                {cm_q, grp_q, op_q} <= map_pass(2'd0, lmul, lanes);
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (pcnt == last_pass(lmul_q, lanes_q)) begin
                            state  <= S_DRAIN;
                            dcnt   <= 3'd1;
                            done_q <= (LAT == 1);
                            pcnt   <= '0;
                            iv_q   <= 1'b0;
                            grp_q  <= '0;
                            op_q   <= '0;
                            cm_q   <= '0;
                        end else begin
                            pcnt <= pcnt + 2'd1;
                            {cm_q, grp_q, op_q} <= map_pass(pcnt + 2'd1, lmul_q, lanes_q);
                        end
                    end
                    S_DRAIN: begin
                        if (dcnt == 3'(LAT)) begin
                            state  <= S_IDLE;
                            done_q <= 1'b0;
                        end else begin
                            dcnt   <= dcnt + 3'd1;
                            done_q <= ((dcnt + 3'd1) == 3'(LAT));
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // hold masks the strobes combinationally so the frozen state replays intact afterwards
    assign busy        = (state != S_IDLE);
    assign issue_valid = iv_q & ~hold;
    assign pass_idx    = pcnt;
    assign grp_en      = hold ? 4'b0 : grp_q;
    assign op_sel      = op_q;
    assign wr_en       = hold ? 4'b0 : pipe[LAT-1];
    assign done        = done_q & ~hold;
    assign err         = err_q;

endmodule

// File: tb/tb_v_lane_sequencer.sv
// tb/tb_v_lane_sequencer.sv - directed checks of v_lane_sequencer at LAT=1 and LAT=2
module tb_v_lane_sequencer;

    logic       clk = 1'b0;
    logic       nrst, start, hold;
    logic [1:0] lmul, lanes;

    logic       busy1, iv1, done1, err1;
    logic [1:0] pidx1;
    logic [3:0] grp1, wr1;
    logic [7:0] op1;
    logic       busy2, iv2, done2, err2;
    logic [1:0] pidx2;
    logic [3:0] grp2, wr2;
    logic [7:0] op2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    v_lane_sequencer #(.LAT(1)) dut1 (
        .clk(clk), .nrst(nrst), .start(start), .lmul(lmul), .lanes(lanes), .hold(hold),
        .busy(busy1), .issue_valid(iv1), .pass_idx(pidx1), .grp_en(grp1), .op_sel(op1),
        .wr_en(wr1), .done(done1), .err(err1)
    );

    v_lane_sequencer #(.LAT(2)) dut2 (
        .clk(clk), .nrst(nrst), .start(start), .lmul(lmul), .lanes(lanes), .hold(hold),
        .busy(busy2), .issue_valid(iv2), .pass_idx(pidx2), .grp_en(grp2), .op_sel(op2),
        .wr_en(wr2), .done(done2), .err(err2)
    );

    // packed view: {busy, issue_valid, pass_idx, grp_en, op_sel, wr_en, done, err}
    function automatic logic [21:0] pk(logic b, logic iv, logic [1:0] p, logic [3:0] g,
                                       logic [7:0] o, logic [3:0] w, logic d, logic e);
        return {b, iv, p, g, o, w, d, e};
    endfunction

    task automatic check(input string tag, input logic [21:0] obs, input logic [21:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %06h expected %06h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic look1(input string tag, input logic [21:0] exp);
        #1;
        check(tag, pk(busy1, iv1, pidx1, grp1, op1, wr1, done1, err1), exp);
    endtask

    task automatic look2(input string tag, input logic [21:0] exp);
        #1;
        check(tag, pk(busy2, iv2, pidx2, grp2, op2, wr2, done2, err2), exp);
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) next_cycle();
    endtask

    initial begin
        nrst = 1'b0; start = 1'b0; hold = 1'b0; lmul = 2'b00; lanes = 2'b00;
        repeat (2) next_cycle();
        look1("reset1", pk(0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0));
        look2("reset2", pk(0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0));
        nrst = 1'b1;
        idle(2);

        // LAT=1, one group, four chunks; config changed mid-operation must be ignored
        start = 1'b1; lmul = 2'b10; lanes = 2'b00;
        next_cycle(); start = 1'b0; lmul = 2'b00; lanes = 2'b10;
        look1("t1_c1", pk(1, 1, 0, 4'h1, 8'h00, 4'h0, 0, 0));
        next_cycle(); look1("t1_c2", pk(1, 1, 1, 4'h1, 8'h01, 4'h1, 0, 0));
        next_cycle(); look1("t1_c3", pk(1, 1, 2, 4'h1, 8'h02, 4'h2, 0, 0));
        next_cycle(); look1("t1_c4", pk(1, 1, 3, 4'h1, 8'h03, 4'h4, 0, 0));
        next_cycle(); look1("t1_c5", pk(1, 0, 0, 4'h0, 8'h00, 4'h8, 1, 0));
        next_cycle(); look1("t1_c6", pk(0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0));
        idl_gap: idle(3);

        // LAT=2, two groups, four chunks
        start = 1'b1; lmul = 2'b10; lanes = 2'b01;
        next_cycle(); start = 1'b0;
        look2("t2_c1", pk(1, 1, 0, 4'h3, 8'h04, 4'h0, 0, 0));
        next_cycle(); look2("t2_c2", pk(1, 1, 1, 4'h3, 8'h0E, 4'h0, 0, 0));
        next_cycle(); look2("t2_c3", pk(1, 0, 0, 4'h0, 8'h00, 4'h3, 0, 0));
        next_cycle(); look2("t2_c4", pk(1, 0, 0, 4'h0, 8'h00, 4'hC, 1, 0));
        next_cycle(); look2("t2_c5", pk(0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0));
        idle(3);

        // four groups, one chunk: groups beyond N stay off
        start = 1'b1; lmul = 2'b00; lanes = 2'b10;
        next_cycle(); start = 1'b0;
        look1("t3a_c1", pk(1, 1, 0, 4'h1, 8'h00, 4'h0, 0, 0));
        next_cycle(); look1("t3a_c2", pk(1, 0, 0, 4'h0, 8'h00, 4'h1, 1, 0));
        next_cycle(); look1("t3a_c3", pk(0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0));
        idle(2);

        // four groups, four chunks in one pass; back-to-back start in the first idle cycle
        start = 1'b1; lmul = 2'b10; lanes = 2'b10;
        next_cycle(); start = 1'b0;
        look1("t3b_c1", pk(1, 1, 0, 4'hF, 8'hE4, 4'h0, 0, 0));
        next_cycle(); look1("t3b_c2", pk(1, 0, 0, 4'h0, 8'h00, 4'hF, 1, 0));
        next_cycle(); start = 1'b1; lmul = 2'b00; lanes = 2'b00;
        look1("t3b_c3", pk(0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0));
        next_cycle(); start = 1'b0;
        look1("t3c_c1", pk(1, 1, 0, 4'h1, 8'h00, 4'h0, 0, 0));
        next_cycle(); look1("t3c_c2", pk(1, 0, 0, 4'h0, 8'h00, 4'h1, 1, 0));
        idle(3);

        // reserved configs raise a single err pulse
        start = 1'b1; lmul = 2'b11; lanes = 2'b00;
        next_cycle(); start = 1'b0;
        look1("t4a_c1", pk(0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 1));
        next_cycle(); look1("t4a_c2", pk(0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0));
        idle(1);
        start = 1'b1; lmul = 2'b00; lanes = 2'b11;
        next_cycle(); start = 1'b0;
        look2("t4b_c1", pk(0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 1));
        next_cycle(); look2("t4b_c2", pk(0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0));
        idle(3);

        // hold in cycle 2 delays pass 1; start during the operation is ignored
        start = 1'b1; lmul = 2'b01; lanes = 2'b00;
        next_cycle(); start = 1'b0;
        look1("t5_c1", pk(1, 1, 0, 4'h1, 8'h00, 4'h0, 0, 0));
        next_cycle(); hold = 1'b1; start = 1'b1;
        look1("t5_c2", pk(1, 0, 1, 4'h0, 8'h01, 4'h0, 0, 0));
        next_cycle(); hold = 1'b0; start = 1'b0;
        look1("t5_c3", pk(1, 1, 1, 4'h1, 8'h01, 4'h1, 0, 0));
        next_cycle(); look1("t5_c4", pk(1, 0, 0, 4'h0, 8'h00, 4'h2, 1, 0));
        next_cycle(); look1("t5_c5", pk(0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0));
        next_cycle(); look1("t5_c6", pk(0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0));
        idle(3);

        // hold in IDLE blocks acceptance of start
        start = 1'b1; hold = 1'b1; lmul = 2'b00; lanes = 2'b00;
        next_cycle(); hold = 1'b0; start = 1'b0;
        look1("t5h_c1", pk(0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0));
        idle(2);

        // reset in cycle 2 abandons the operation; a fresh start in cycle 3 completes
        start = 1'b1; lmul = 2'b10; lanes = 2'b00;
        next_cycle(); start = 1'b0;
        look1("t6_c1", pk(1, 1, 0, 4'h1, 8'h00, 4'h0, 0, 0));
        next_cycle(); nrst = 1'b0;
        look1("t6_c2", pk(1, 1, 1, 4'h1, 8'h01, 4'h1, 0, 0));
        next_cycle(); nrst = 1'b1; start = 1'b1;
        look1("t6_c3", pk(0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0));
        next_cycle(); start = 1'b0;
        look1("t6_c4", pk(1, 1, 0, 4'h1, 8'h00, 4'h0, 0, 0));
        next_cycle(); look1("t6_c5", pk(1, 1, 1, 4'h1, 8'h01, 4'h1, 0, 0));
        next_cycle(); look1("t6_c6", pk(1, 1, 2, 4'h1, 8'h02, 4'h2, 0, 0));
        next_cycle(); look1("t6_c7", pk(1, 1, 3, 4'h1, 8'h03, 4'h4, 0, 0));
        next_cycle(); look1("t6_c8", pk(1, 0, 0, 4'h0, 8'h00, 4'h8, 1, 0));
        next_cycle(); look1("t6_c9", pk(0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
